// File: rtl/ten_min_timer.sv
`default_nettype none
// ============================================================================
// Module      : ten_min_timer
// Description : Ten-minute stopwatch. A prescaler divides CLOCK_50 down to a
//               0.1 s tick that advances a cascaded BCD count M:ST.SO.T from
//               0:00.0 to 9:59.9, after which it wraps to 0:00.0.
// Revision    : 1.0 - initial release
// ============================================================================
module ten_min_timer #(
  parameter int CLKS_PER_TENTH = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  output logic [3:0] minutes,
  output logic [2:0] secondTens,
  output logic [3:0] secondOnes,
  output logic [3:0] tenthsOut
);

  // Prescaler width; a divide-by-one still needs a one-bit register.
  localparam int C_PRE_W = (CLKS_PER_TENTH > 1) ? $clog2(CLKS_PER_TENTH) : 1;
  localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(CLKS_PER_TENTH - 1);

  // Digit terminal values: reaching (or somehow exceeding) these rolls to 0.
  localparam logic [3:0] C_TENTHS_MAX  = 4'd9;
  localparam logic [3:0] C_SEC_ONE_MAX = 4'd9;
  localparam logic [2:0] C_SEC_TEN_MAX = 3'd5;
  localparam logic [3:0] C_MIN_MAX     = 4'd9;

  logic [C_PRE_W-1:0] pre_q,     pre_d;
  logic [3:0]         tenths_q,  tenths_d;
  logic [3:0]         sec_one_q, sec_one_d;
  logic [2:0]         sec_ten_q, sec_ten_d;
  logic [3:0]         min_q,     min_d;

  logic w_tick;
  logic w_carry_tenths;
  logic w_carry_sec_one;
  logic w_carry_sec_ten;

  // Tenth-second tick: qualified by enable so a paused timer never advances.
  assign w_tick = enable && (pre_q == C_PRE_MAX);

  // Prescaler next state: count while enabled, restart on tick, else hold.
  always_comb begin
    pre_d = pre_q;
    if (enable) begin
      if (pre_q == C_PRE_MAX) begin
        pre_d = '0;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Tenths digit; ">=" makes any illegal code recover to 0 with a carry.
  always_comb begin
    tenths_d       = tenths_q;
    w_carry_tenths = 1'b0;
    if (w_tick) begin
      if (tenths_q >= C_TENTHS_MAX) begin
        tenths_d       = 4'd0;
        w_carry_tenths = 1'b1;
      end else begin
        tenths_d = tenths_q + 4'd1;
      end
    end
  end

  // Seconds-ones digit, advanced by the tenths carry on the same edge.
  always_comb begin
    sec_one_d       = sec_one_q;
    w_carry_sec_one = 1'b0;
    if (w_carry_tenths) begin
      if (sec_one_q >= C_SEC_ONE_MAX) begin
        sec_one_d       = 4'd0;
        w_carry_sec_one = 1'b1;
      end else begin
        sec_one_d = sec_one_q + 4'd1;
      end
    end
  end

  // Seconds-tens digit (0..5), advanced by the seconds-ones carry.
  always_comb begin
    sec_ten_d       = sec_ten_q;
    w_carry_sec_ten = 1'b0;
    if (w_carry_sec_one) begin
      if (sec_ten_q >= C_SEC_TEN_MAX) begin
        sec_ten_d       = 3'd0;
        w_carry_sec_ten = 1'b1;
      end else begin
        sec_ten_d = sec_ten_q + 3'd1;
      end
    end
  end

  // Minutes digit; its roll-over is the full 9:59.9 -> 0:00.0 wrap.
  always_comb begin
    min_d = min_q;
    if (w_carry_sec_ten) begin
      if (min_q >= C_MIN_MAX) begin
        min_d = 4'd0;
      end else begin
        min_d = min_q + 4'd1;
      end
    end
  end

  // State registers; reset clears everything immediately and asynchronously.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      pre_q     <= '0;
      tenths_q  <= 4'd0;
      sec_one_q <= 4'd0;
      sec_ten_q <= 3'd0;
      min_q     <= 4'd0;
    end else begin
      pre_q     <= pre_d;
      tenths_q  <= tenths_d;
      sec_one_q <= sec_one_d;
      sec_ten_q <= sec_ten_d;
      min_q     <= min_d;
    end
  end

  // Outputs are taken straight from the digit registers.
  assign minutes    = min_q;
  assign secondTens = sec_ten_q;
  assign secondOnes = sec_one_q;
  assign tenthsOut  = tenths_q;

endmodule
`default_nettype wire

// File: tb/tb_ten_min_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ten_min_timer
// Description : Directed, table-driven bench for ten_min_timer with
//               CLKS_PER_TENTH = 5 and a 20 ns clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ten_min_timer;

  localparam int C_CLKS = 5;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] minutes;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] tenths;

  int n_checks;
  int n_errors;

  typedef struct {
    logic       en;
    int         edges;
    logic [3:0] m;
    logic [2:0] st;
    logic [3:0] so;
    logic [3:0] t;
  } vec_t;

  vec_t vecs [14];

  ten_min_timer #(
    .CLKS_PER_TENTH(C_CLKS)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .enable    (en),
    .minutes   (minutes),
    .secondTens(sec_tens),
    .secondOnes(sec_ones),
    .tenthsOut (tenths)
  );

  // 20 ns clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] m, input logic [2:0] st,
                       input logic [3:0] so, input logic [3:0] t);
    n_checks++;
    if ({minutes, sec_tens, sec_ones, tenths} !== {m, st, so, t}) begin
      n_errors++;
      $display("FAIL %s: got %0d:%0d%0d.%0d expected %0d:%0d%0d.%0d",
               name, minutes, sec_tens, sec_ones, tenths, m, st, so, t);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic run_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Cumulative edge counts from reset release are noted per row.
    vecs[0]  = '{1'b1,     4, 4'd0, 3'd0, 4'd0, 4'd0}; //     4: no tick yet
    vecs[1]  = '{1'b1,     1, 4'd0, 3'd0, 4'd0, 4'd1}; //     5: first tick
    vecs[2]  = '{1'b1,    45, 4'd0, 3'd0, 4'd1, 4'd0}; //    50: 0:01.0
    vecs[3]  = '{1'b1,   445, 4'd0, 3'd0, 4'd9, 4'd9}; //   495: 0:09.9
    vecs[4]  = '{1'b1,     5, 4'd0, 3'd1, 4'd0, 4'd0}; //   500: 0:10.0
    vecs[5]  = '{1'b1,  2495, 4'd0, 3'd5, 4'd9, 4'd9}; //  2995: 0:59.9
    vecs[6]  = '{1'b1,     5, 4'd1, 3'd0, 4'd0, 4'd0}; //  3000: 1:00.0
    vecs[7]  = '{1'b1, 26995, 4'd9, 3'd5, 4'd9, 4'd9}; // 29995: 9:59.9
    vecs[8]  = '{1'b1,     5, 4'd0, 3'd0, 4'd0, 4'd0}; // 30000: wrap
    vecs[9]  = '{1'b1,    17, 4'd0, 3'd0, 4'd0, 4'd3}; // 0:00.3, pre=2
    vecs[10] = '{1'b0,    37, 4'd0, 3'd0, 4'd0, 4'd3}; // paused, frozen
    vecs[11] = '{1'b1,     2, 4'd0, 3'd0, 4'd0, 4'd3}; // pre 2->4
    vecs[12] = '{1'b1,     1, 4'd0, 3'd0, 4'd0, 4'd4}; // 3rd edge: tick
    vecs[13] = '{1'b1,    10, 4'd0, 3'd0, 4'd0, 4'd6}; // 0:00.6

    // Reset state while held with enable low.
    rst = 1'b1;
    en  = 1'b0;
    run_edges(3);
    check("reset_state", 4'd0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven main run.
    for (int i = 0; i < 14; i++) begin
      en = vecs[i].en;
      run_edges(vecs[i].edges);
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].st, vecs[i].so, vecs[i].t);
    end

    // Asynchronous reset mid-count: outputs clear before the next edge.
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    check("async_reset_now", 4'd0, 3'd0, 4'd0, 4'd0);

    // Reset and enable together: outputs stay zero across many edges.
    en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      run_edges(1);
      check($sformatf("reset_hold%0d", k), 4'd0, 3'd0, 4'd0, 4'd0);
    end

    // Release with enable high: first increment on the 5th edge.
    @(negedge clk);
    rst = 1'b0;
    run_edges(4);
    check("post_reset_4", 4'd0, 3'd0, 4'd0, 4'd0);
    run_edges(1);
    check("post_reset_5", 4'd0, 3'd0, 4'd0, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
